diff_commit_source: RTL

Producer side of the difftest commit port. It accepts retire records from the writeback stage over a valid/ready handshake and buffers them in a small FIFO. It then drives one commit per cycle onto the difftest bridge fields: instruction commit, load/store events and exception event. It also maintains a shadow GPR file and a commit counter, and raises a sticky no-commit watchdog flag.

---
 rtl/diff_commit_source.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/diff_commit_source.sv
// Difftest commit-port producer: buffers retire records in a small FIFO and emits one
// registered commit per cycle, keeping a shadow GPR file, a commit counter and a watchdog.
module diff_commit_source #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [63:0]     in_pc,
    input  logic [31:0]     in_instr,
    input  logic            in_skip,
    input  logic            in_wen,
    input  logic [7:0]      in_wdest,
    input  logic [63:0]     in_wdata,
    input  logic            in_excp,
    input  logic            in_isMret,
    input  logic [31:0]     in_cause,
    input  logic [7:0]      in_stValid,
    input  logic [63:0]     in_stPaddr,
    input  logic [63:0]     in_stData,
    input  logic [7:0]      in_ldValid,
    input  logic [63:0]     in_ldPaddr,
    input  logic [63:0]     in_ldData,
    output logic            instrValid,
    output logic [7:0]      index,
    output logic [63:0]     the_pc,
    output logic [31:0]     instr,
    output logic            skip,
    output logic            wen,
    output logic [7:0]      wdest,
    output logic [63:0]     wdata,
    output logic            excp_valid,
    output logic            isMret,
    output logic [31:0]     cause,
    output logic [63:0]     exceptionPC,
    output logic [31:0]     exceptionInst,
    output logic [7:0]      storeValid,
    output logic [63:0]     storePaddr,
    output logic [63:0]     storeVaddr,
    output logic [63:0]     storeData,
    output logic [7:0]      loadValid,
    output logic [63:0]     loadPaddr,
    output logic [63:0]     loadVaddr,
    output logic [63:0]     loadData,
    output logic [2047:0]   gpr,
    output logic [63:0]     commit_cnt,
    output logic            timeout
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        skip;
        logic        wen;
        logic [7:0]  wdest;
        logic [63:0] wdata;
        logic        excp;
        logic        mret;
        logic [31:0] cause;
        logic [7:0]  st_valid;
        logic [63:0] st_paddr;
        logic [63:0] st_data;
        logic [7:0]  ld_valid;
        logic [63:0] ld_paddr;
        logic [63:0] ld_data;
    } rec_t;

    rec_t          mem [DEPTH];
    rec_t          in_rec;
    rec_t          head_rec;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic [7:0]    seq;
    logic [IW-1:0] idle;
    logic [63:0]   gpr_q [32];
    logic          push;
    logic          pop;
    logic          gpr_write;

    always_comb begin
        in_rec          = '0;
        in_rec.pc       = in_pc;
        in_rec.instr    = in_instr;
        in_rec.skip     = in_skip;
        in_rec.wen      = in_wen;
        in_rec.wdest    = in_wdest;
        in_rec.wdata    = in_wdata;
        in_rec.excp     = in_excp;
        in_rec.mret     = in_isMret;
        in_rec.cause    = in_cause;
        in_rec.st_valid = in_stValid;
        in_rec.st_paddr = in_stPaddr;
        in_rec.st_data  = in_stData;
        in_rec.ld_valid = in_ldValid;
        in_rec.ld_paddr = in_ldPaddr;
        in_rec.ld_data  = in_ldData;
    end

    // in_ready depends only on the occupancy register, so a full FIFO refuses a push
    // even when the head is popped on the same edge.
    assign in_ready  = (count != CW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign pop       = (count != '0);
    assign head_rec  = mem[head];
    assign gpr_write = pop && head_rec.wen && !head_rec.excp &&
                       (head_rec.wdest != 8'd0) && (head_rec.wdest < 8'd32);

    assign storeVaddr = storePaddr;
    assign loadVaddr  = loadPaddr;

    for (genvar g = 0; g < 32; g++) begin : g_gpr
        assign gpr[64*g +: 64] = gpr_q[g];
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[tail] <= in_rec;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            seq           <= '0;
            idle          <= '0;
            timeout       <= 1'b0;
            commit_cnt    <= '0;
            instrValid    <= 1'b0;
            index         <= '0;
            the_pc        <= '0;
            instr         <= '0;
            skip          <= 1'b0;
            wen           <= 1'b0;
            wdest         <= '0;
            wdata         <= '0;
            excp_valid    <= 1'b0;
            isMret        <= 1'b0;
            cause         <= '0;
            exceptionPC   <= '0;
            exceptionInst <= '0;
            storeValid    <= '0;
            storePaddr    <= '0;
            storeData     <= '0;
            loadValid     <= '0;
            loadPaddr     <= '0;
            loadData      <= '0;
            for (int i = 0; i < 32; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            count      <= count + CW'(push) - CW'(pop);
            instrValid <= pop;
            excp_valid <= pop && head_rec.excp;
            storeValid <= pop ? head_rec.st_valid : 8'd0;
            loadValid  <= pop ? head_rec.ld_valid : 8'd0;
            if (pop) begin
                head       <= head + 1'b1;
                index      <= seq;
                seq        <= seq + 8'd1;
                idle       <= '0;
                the_pc     <= head_rec.pc;
                instr      <= head_rec.instr;
                skip       <= head_rec.skip;
                wen        <= head_rec.wen && !head_rec.excp;
                wdest      <= head_rec.wdest;
                wdata      <= head_rec.wdata;
                isMret     <= head_rec.mret;
                cause      <= head_rec.cause;
                storePaddr <= head_rec.st_paddr;
                storeData  <= head_rec.st_data;
                loadPaddr  <= head_rec.ld_paddr;
                loadData   <= head_rec.ld_data;
                if (head_rec.excp) begin
                    exceptionPC   <= head_rec.pc;
                    exceptionInst <= head_rec.instr;
                end else begin
                    commit_cnt <= commit_cnt + 64'd1;
                end
                if (gpr_write) begin
                    gpr_q[head_rec.wdest[4:0]] <= head_rec.wdata;
                end
            end else if (idle == IW'(TIMEOUT - 1)) begin
                timeout <= 1'b1;
            end else begin
                idle <= idle + 1'b1;
            end
        end
    end
endmodule
